// File: rtl/sudoku_pkg.sv
// sudoku_pkg: grid constants, checker state encoding and cell addressing shared by the sudoku blocks.
package sudoku_pkg;
    localparam int CELL_W = 4;
    localparam int GRID_N = 9;
    localparam int CELL_COUNT = 81;
    localparam logic [6:0] NO_CELL = 7'h7F;

    typedef enum logic [2:0] {IDLE, SCAN_ROW, SCAN_COL, SCAN_BOX, DONE} chk_state_t;

    function automatic logic [6:0] cell_at(input logic [3:0] r, input logic [3:0] c);
        return {3'b000, r} * 7'd9 + {3'b000, c};
    endfunction
endpackage

// File: rtl/cell_coord.sv
// cell_coord: splits a linear cell index into row, column and the top-left corner of its 3x3 box.
module cell_coord (
    input  logic [6:0] index,
    output logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] box_row,
    output logic [3:0] box_col
);
    assign row = 4'(index / 7'd9);
    assign col = 4'(index % 7'd9);
    assign box_row = row / 4'd3 * 4'd3;
    assign box_col = col / 4'd3 * 4'd3;
endmodule

// File: rtl/conflict_checker.sv
// conflict_checker: scans row, column and (with CONFLICT_BOX_CHECK_EN) box of a candidate cell for a duplicate digit.
// One cell is examined per clock; latency is fixed regardless of the outcome.
module conflict_checker
    import sudoku_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CELL_COUNT*CELL_W-1:0] board,
    input  logic                         req,
    input  logic [6:0]                   cell_index,
    input  logic [3:0]                   value,
    output logic                         busy,
    output logic                         done,
    output logic                         conflict,
    output logic [6:0]                   first_conflict
);
    localparam logic [3:0] LAST_K = 4'(GRID_N - 1);

    chk_state_t state, after;
    logic [6:0] idx, scan;
    logic [3:0] val, cnt, row, col, box_row, box_col;
    logic skip, hit, last;

    cell_coord u_coord (
        .index(idx),
        .row(row),
        .col(col),
        .box_row(box_row),
        .box_col(box_col)
    );

    // Out-of-range or empty candidates run one idle scan cycle and then finish.
    always_comb begin
        skip = val == 4'd0 || val > 4'd9 || idx > 7'(CELL_COUNT - 1);
        last = cnt == LAST_K;
        scan = state == SCAN_ROW ? cell_at(row, cnt) :
               state == SCAN_COL ? cell_at(cnt, col) :
               cell_at(box_row + cnt / 4'd3, box_col + cnt % 4'd3);
        hit = !skip && board[{scan, 2'b00} +: CELL_W] == val && scan != idx;
`ifdef CONFLICT_BOX_CHECK_EN
        after = state == SCAN_ROW ? SCAN_COL : state == SCAN_COL ? SCAN_BOX : DONE;
`else
        after = state == SCAN_ROW ? SCAN_COL : DONE;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            conflict <= 1'b0;
            first_conflict <= NO_CELL;
            cnt <= 4'd0;
            idx <= 7'd0;
            val <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    idx <= cell_index;
                    val <= value;
                    conflict <= value != 4'd0 && (value > 4'd9 || cell_index > 7'(CELL_COUNT - 1));
                    first_conflict <= NO_CELL;
                    cnt <= 4'd0;
                    busy <= 1'b1;
                    state <= SCAN_ROW;
                end
                DONE: begin
                    state <= IDLE;
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: begin
                    if (hit && !conflict) begin
                        conflict <= 1'b1;
                        first_conflict <= scan;
                    end
                    cnt <= last ? 4'd0 : cnt + 4'd1;
                    state <= skip ? DONE : last ? after : state;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_conflict_checker.sv
// tb_conflict_checker: directed and randomized checks of conflict_checker against a list-based model.
// Build with or without CONFLICT_BOX_CHECK_EN to match the design under test.
module tb_conflict_checker;
`ifdef CONFLICT_BOX_CHECK_EN
    localparam int LAT = 28;
    localparam bit BOX = 1'b1;
`else
    localparam int LAT = 19;
    localparam bit BOX = 1'b0;
`endif

    logic clk = 1'b0, reset = 1'b0, req = 1'b0;
    logic [323:0] board;
    logic [6:0] cell_index = 7'd0;
    logic [3:0] value = 4'd0;
    logic busy, done, conflict;
    logic [6:0] first_conflict;
    logic [3:0] cells [81];
    int vectors = 0, errors = 0;

    always #5 clk = ~clk;

    always_comb for (int i = 0; i < 81; i++) board[4*i +: 4] = cells[i];

    conflict_checker dut (
        .clk(clk),
        .reset(reset),
        .board(board),
        .req(req),
        .cell_index(cell_index),
        .value(value),
        .busy(busy),
        .done(done),
        .conflict(conflict),
        .first_conflict(first_conflict)
    );

    task automatic clear_board;
        foreach (cells[j]) cells[j] = 4'd0;
    endtask

    // Reference: gather the peers in scan order, report the first one holding the digit.
    function automatic void model(input logic [6:0] i, input logic [3:0] v,
                                  output logic c, output logic [6:0] f, output int lat);
        int r, q;
        int peers[$];
        c = 1'b0;
        f = 7'h7F;
        lat = 2;
        if (v == 0) return;
        if (v > 9 || i > 80) begin
            c = 1'b1;
            return;
        end
        lat = LAT;
        r = i / 9;
        q = i % 9;
        for (int k = 0; k < 9; k++) peers.push_back(r * 9 + k);
        for (int k = 0; k < 9; k++) peers.push_back(k * 9 + q);
        if (BOX) for (int k = 0; k < 9; k++) peers.push_back((r / 3 * 3 + k / 3) * 9 + q / 3 * 3 + k % 3);
        foreach (peers[n])
            if (!c && peers[n] != int'(i) && cells[peers[n]] == v) begin
                c = 1'b1;
                f = 7'(peers[n]);
            end
    endfunction

    // Issues one request from a negedge; returns edges-to-done and the sampled results.
    task automatic do_req(input logic [6:0] i, input logic [3:0] v, input bit poke,
                          output int lat, output logic c, output logic [6:0] f,
                          output logic b, output logic once);
        bit found;
        cell_index = i;
        value = v;
        req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        b = busy;
        lat = 0;
        found = 1'b0;
        while (!found && lat < 60) begin
            @(posedge clk);
            lat++;
            #1;
            if (poke && lat == 5) begin
                req = 1'b1;
                cell_index = 7'd0;
                value = 4'd9;
            end
            if (lat == 6) req = 1'b0;
            found = done;
        end
        c = conflict;
        f = first_conflict;
        @(posedge clk);
        #1 once = !done;
        @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++; if (conflict !== 1'b0) begin errors++; $display("FAIL reset_conflict: got %b want 0", conflict); end
        vectors++; if (first_conflict !== 7'h7F) begin errors++; $display("FAIL reset_first: got %h want 7f", first_conflict); end
        reset = 1'b1;
    endtask

    task automatic test_empty_board;
        int lat; logic c, b, once; logic [6:0] f;
        clear_board;
        do_req(7'd40, 4'd5, 1'b0, lat, c, f, b, once);
        vectors++; if (lat !== LAT) begin errors++; $display("FAIL empty_latency: got %0d want %0d", lat, LAT); end
        vectors++; if (c !== 1'b0) begin errors++; $display("FAIL empty_conflict: got %b want 0", c); end
        vectors++; if (f !== 7'h7F) begin errors++; $display("FAIL empty_first: got %0d want 127", f); end
        vectors++; if (b !== 1'b1) begin errors++; $display("FAIL empty_busy: got %b want 1", b); end
        vectors++; if (once !== 1'b1) begin errors++; $display("FAIL empty_done_width: done still high next cycle"); end
    endtask

    task automatic test_conflicts;
        int lat; logic c, b, once; logic [6:0] f, ef; logic [3:0] v;
        for (int s = 0; s < 3; s++) begin
            clear_board;
            case (s)
                0: begin cells[36] = 4'd5; v = 4'd5; ef = 7'd36; end
                1: begin cells[4] = 4'd7; cells[30] = 4'd7; v = 4'd7; ef = 7'd4; end
                default: begin cells[44] = 4'd2; cells[76] = 4'd2; cells[50] = 4'd2; v = 4'd2; ef = 7'd44; end
            endcase
            do_req(7'd40, v, 1'b0, lat, c, f, b, once);
            vectors++; if (lat !== LAT) begin errors++; $display("FAIL conflict%0d_latency: got %0d want %0d", s, lat, LAT); end
            vectors++; if (c !== 1'b1) begin errors++; $display("FAIL conflict%0d_flag: got %b want 1", s, c); end
            vectors++; if (f !== ef) begin errors++; $display("FAIL conflict%0d_first: got %0d want %0d", s, f, ef); end
        end
    endtask

    task automatic test_short_path;
        int lat; logic c, b, once; logic [6:0] f;
        clear_board;
        do_req(7'd10, 4'd0, 1'b0, lat, c, f, b, once);
        vectors++; if (lat !== 2) begin errors++; $display("FAIL zero_latency: got %0d want 2", lat); end
        vectors++; if (c !== 1'b0) begin errors++; $display("FAIL zero_conflict: got %b want 0", c); end
        do_req(7'd81, 4'd3, 1'b0, lat, c, f, b, once);
        vectors++; if (lat !== 2) begin errors++; $display("FAIL badidx_latency: got %0d want 2", lat); end
        vectors++; if (c !== 1'b1) begin errors++; $display("FAIL badidx_conflict: got %b want 1", c); end
        vectors++; if (f !== 7'h7F) begin errors++; $display("FAIL badidx_first: got %0d want 127", f); end
        do_req(7'd12, 4'd11, 1'b0, lat, c, f, b, once);
        vectors++; if (lat !== 2) begin errors++; $display("FAIL badval_latency: got %0d want 2", lat); end
        vectors++; if (c !== 1'b1) begin errors++; $display("FAIL badval_conflict: got %b want 1", c); end
    endtask

    task automatic test_busy_ignore;
        int lat; logic c, b, once; logic [6:0] f;
        clear_board;
        cells[30] = 4'd7;
        do_req(7'd40, 4'd7, 1'b1, lat, c, f, b, once);
        vectors++; if (lat !== LAT) begin errors++; $display("FAIL ignore_latency: got %0d want %0d", lat, LAT); end
        vectors++; if (c !== BOX) begin errors++; $display("FAIL ignore_conflict: got %b want %b", c, BOX); end
        vectors++; if (f !== (BOX ? 7'd30 : 7'h7F)) begin errors++; $display("FAIL ignore_first: got %0d", f); end
    endtask

    task automatic test_reset_abort;
        bit seen;
        int lat; logic c, b, once; logic [6:0] f;
        clear_board;
        cells[36] = 4'd5;
        cell_index = 7'd40;
        value = 4'd5;
        req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        vectors++; if (conflict !== 1'b0) begin errors++; $display("FAIL abort_conflict: got %b want 0", conflict); end
        vectors++; if (first_conflict !== 7'h7F) begin errors++; $display("FAIL abort_first: got %0d want 127", first_conflict); end
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1 if (done) seen = 1'b1;
        end
        vectors++; if (seen) begin errors++; $display("FAIL abort_done: got pulse want none"); end
        @(negedge clk);
        reset = 1'b1;
        do_req(7'd40, 4'd5, 1'b0, lat, c, f, b, once);
        vectors++; if (lat !== LAT) begin errors++; $display("FAIL after_reset_latency: got %0d want %0d", lat, LAT); end
        vectors++; if (f !== 7'd36) begin errors++; $display("FAIL after_reset_first: got %0d want 36", f); end
    endtask

    task automatic test_random;
        int lat, el, d; logic c, b, once, ec; logic [6:0] f, ef, i; logic [3:0] v;
        for (int n = 0; n < 40; n++) begin
            d = $urandom_range(1, 6);
            foreach (cells[j]) cells[j] = ($urandom_range(0, d) == 0) ? 4'($urandom_range(1, 9)) : 4'd0;
            i = 7'($urandom_range(0, 80));
            v = 4'($urandom_range(1, 9));
            if (n % 10 == 9) v = 4'($urandom_range(10, 15));
            if (n % 10 == 4) i = 7'($urandom_range(81, 127));
            model(i, v, ec, ef, el);
            do_req(i, v, 1'b0, lat, c, f, b, once);
            vectors++; if (lat !== el) begin errors++; $display("FAIL rand%0d_latency: got %0d want %0d", n, lat, el); end
            vectors++; if (c !== ec) begin errors++; $display("FAIL rand%0d_conflict: got %b want %b (idx %0d val %0d)", n, c, ec, i, v); end
            vectors++; if (f !== ef) begin errors++; $display("FAIL rand%0d_first: got %0d want %0d (idx %0d val %0d)", n, f, ef, i, v); end
        end
    endtask

    initial begin
        clear_board;
        test_reset;
        test_empty_board;
        test_conflicts;
        test_short_path;
        test_busy_ignore;
        test_reset_abort;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/conflict_checker.md
CONFLICT_CHECKER -- requirements
Module: conflict_checker

Interface
REQ-001 SHALL have port clk, input, 1, single game clock; all state advances on its rising edge.
REQ-002 SHALL have port reset, input, 1, one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port board, input, 324, 81 cells x 4 bits; cell i at bits [4i+3:4i]; i = row*9+col; value 0 = empty.
REQ-004 SHALL have port req, input, 1, start a check; sampled only when busy=0.
REQ-005 SHALL have port cell_index, input, 7, candidate cell 0..80; sampled with req.
REQ-006 SHALL have port value, input, 4, candidate digit 1..9; sampled with req.
REQ-007 SHALL have port busy, output, 1, high from the cycle after accept until done.
REQ-008 SHALL have port done, output, 1, single-cycle completion pulse.
REQ-009 SHALL have port conflict, output, 1, result; valid from done, held until next accept.
REQ-010 SHALL have port first_conflict, output, 7, index of first conflicting cell found; 7'h7F if none.

Function
REQ-011 SHALL implement states IDLE, SCAN_ROW, SCAN_COL, SCAN_BOX, DONE.
REQ-012 SHALL, in IDLE with req=1, latch cell_index and value, clear conflict, set first_conflict=7'h7F, and enter SCAN_ROW with scan counter 0.
REQ-013 SHALL examine exactly one cell per cycle per scan state, counter 0..8: row cell row*9+k; column cell k*9+col; box cell (3*(row/3)+k/3)*9 + 3*(col/3)+k%3.
REQ-014 SHALL skip the candidate's own cell in every scan.
REQ-015 SHALL flag a match when the examined cell equals the latched value; the first match sets conflict=1 and loads first_conflict; later matches leave first_conflict unchanged.
REQ-016 SHALL always run all scans (no early exit): fixed latency regardless of result.
REQ-017 SHALL transition SCAN_ROW->SCAN_COL->SCAN_BOX->DONE when counter reaches 8; DONE->IDLE unconditionally.
REQ-018 SHALL assert done for exactly one cycle, 28 rising edges after the accepting edge (27 scan cycles + DONE).
REQ-019 SHALL complete with done 2 edges after accept, skipping all scans, when value=0 (conflict=0) or when value>9 or cell_index>80 (conflict=1, first_conflict=7'h7F).
REQ-020 SHALL ignore req while busy=1; req held high in the DONE cycle is not accepted until IDLE.
REQ-021 SHALL NOT latch board; the caller keeps board stable while busy=1 (result otherwise undefined).

Reset
REQ-022 SHALL, on reset low, immediately force IDLE, busy=0, done=0, conflict=0, first_conflict=7'h7F, counter=0, aborting any scan in progress without a done pulse.
REQ-023 SHALL accept a new req on the first rising edge after reset deasserts.

Configuration
REQ-024 SHALL include SCAN_BOX only when macro CONFLICT_BOX_CHECK_EN is defined; latency then 28 edges.
REQ-025 SHALL, without CONFLICT_BOX_CHECK_EN, go SCAN_COL->DONE, with done 19 edges after accept; all else unchanged.

Structure
REQ-026 SHALL take from shared package sudoku_pkg: CELL_W=4, GRID_N=9, CELL_COUNT=81, NO_CELL=7'h7F, and the checker state enum.
REQ-027 SHALL use one combinational sub-module cell_coord (index -> row, col, box origin) instantiated once on the latched index.

Verification
REQ-028 SHALL verify: empty board, req idx=40 val=5 -> done at edge 28, conflict=0, first_conflict=7'h7F.
REQ-029 SHALL verify: cell 36 (row 4, col 0)=5, req idx=40 val=5 -> conflict=1, first_conflict=36.
REQ-030 SHALL verify: cells 4 and 30 both =7, req idx=40 val=7 -> conflict=1, first_conflict=4 (row scan before column scan, cell 4 found in column scan, cell 30 in box scan).
REQ-031 SHALL verify: req val=0 -> done at edge 2, conflict=0; req idx=81 val=3 -> done at edge 2, conflict=1.
REQ-032 SHALL verify: reset asserted at scan cycle 10 -> busy=0 at once, no done pulse; req after release completes normally in 28 edges.
REQ-033 SHALL verify: req pulsed while busy -> ignored; built without CONFLICT_BOX_CHECK_EN, cell 30=7, req idx=40 val=7 -> done at edge 19, conflict=0.
